demux_1ton: RTL and testbench

DEMUX_1TON -- requirements
Module: demux_1toN

---
 rtl/demux_1ton.sv | 98 +++++++++
 tb/tb_demux_1ton.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1ton.sv
// demux_1ton: routes one upstream valid/ready stream to NUM_CH output
// channels. Each channel has a one-entry output register.
//
// Parameters
//   BUS_WIDTH : data beat width in bits (1..32)
//   NUM_CH    : number of output channels, power of two in 2..8
//   MODE      : 0 = round-robin destination, 1 = explicit sel_in destination
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset_L    : asynchronous active-low reset
//   valid_in   : upstream beat valid
//   data_in    : upstream beat data
//   sel_in     : destination channel (MODE 1 only), sampled with valid_in
//   ready_out  : upstream ready (combinational); transfer on valid_in && ready_out
//   ready_in   : per-channel sink ready, bit k = channel k
//   data_out   : channel k data at [k*BUS_WIDTH +: BUS_WIDTH]
//   valid_out  : per-channel data valid, bit k = channel k
//   ch_ptr     : MODE 0 next destination, MODE 1 last accepted destination
module demux_1ton #(
  parameter int unsigned  BUS_WIDTH = 8,
  parameter int unsigned  NUM_CH    = 4,
  parameter int unsigned  MODE      = 0,
  localparam int unsigned PTR_W     = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        valid_in,
  input  logic [BUS_WIDTH-1:0]        data_in,
  input  logic [PTR_W-1:0]            sel_in,
  output logic                        ready_out,
  input  logic [NUM_CH-1:0]           ready_in,
  output logic [NUM_CH*BUS_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]           valid_out,
  output logic [PTR_W-1:0]            ch_ptr
);

  // Channel registers and destination pointer
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] r_data;
  logic [NUM_CH-1:0]                r_valid;
  logic [PTR_W-1:0]                 r_ch_ptr;

  // Next-state values and handshake terms
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] w_data_nxt;
  logic [NUM_CH-1:0]                w_valid_nxt;
  logic [PTR_W-1:0]                 w_ptr_nxt;
  logic [PTR_W-1:0]                 w_dest;
  logic                             w_accept;

  // Destination: pointer in round-robin mode, sideband select otherwise
  assign w_dest = (MODE == 1) ? sel_in : r_ch_ptr;

  // Destination slot can take a beat if empty or draining this cycle;
  // intentionally independent of valid_in.
  assign ready_out = !r_valid[w_dest] || ready_in[w_dest];
  assign w_accept  = valid_in && ready_out;

  // Per-channel load / drain; a load wins over a same-cycle drain so a
  // streaming channel stays valid without a bubble.
  always_comb begin
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (w_accept && (w_dest == PTR_W'(k))) begin
        w_valid_nxt[k] = 1'b1;
        w_data_nxt[k]  = data_in;
      end else if (r_valid[k] && ready_in[k]) begin
        w_valid_nxt[k] = 1'b0;
      end
    end
  end

  // Pointer advance; NUM_CH is a power of two so the increment wraps naturally
  always_comb begin
    w_ptr_nxt = r_ch_ptr;
    if (w_accept) begin
      w_ptr_nxt = (MODE == 1) ? sel_in : PTR_W'(r_ch_ptr + PTR_W'(1));
    end
  end

  // State registers; reset discards any held beats
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data   <= '0;
      r_valid  <= '0;
      r_ch_ptr <= '0;
    end else begin
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_ch_ptr <= w_ptr_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign ch_ptr    = r_ch_ptr;

endmodule

// File: tb/tb_demux_1ton.sv
// Testbench for demux_1ton: directed scenarios on 8-bit/4-channel instances
// in both modes, then randomized traffic on four configurations checked
// against a per-channel slot model.
module tb_demux_1ton;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [15:0] data_in;
  logic [2:0]  sel_in;
  logic [7:0]  ready_in;

  always #5 clk = ~clk;

  // Instance outputs
  logic         rdy0, rdy1, rdy2, rdy3;
  logic [31:0]  dout0, dout1;
  logic [1:0]   dout2;
  logic [127:0] dout3;
  logic [3:0]   v0, v1;
  logic [1:0]   v2;
  logic [7:0]   v3;
  logic [1:0]   p0, p1;
  logic         p2;
  logic [2:0]   p3;

  demux_1ton #(.BUS_WIDTH(8), .NUM_CH(4), .MODE(0)) u_rr4 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in[7:0]),
    .sel_in(sel_in[1:0]), .ready_out(rdy0), .ready_in(ready_in[3:0]),
    .data_out(dout0), .valid_out(v0), .ch_ptr(p0));

  demux_1ton #(.BUS_WIDTH(8), .NUM_CH(4), .MODE(1)) u_sel4 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in[7:0]),
    .sel_in(sel_in[1:0]), .ready_out(rdy1), .ready_in(ready_in[3:0]),
    .data_out(dout1), .valid_out(v1), .ch_ptr(p1));

  demux_1ton #(.BUS_WIDTH(1), .NUM_CH(2), .MODE(0)) u_rr2 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in[0:0]),
    .sel_in(sel_in[0:0]), .ready_out(rdy2), .ready_in(ready_in[1:0]),
    .data_out(dout2), .valid_out(v2), .ch_ptr(p2));

  demux_1ton #(.BUS_WIDTH(16), .NUM_CH(8), .MODE(1)) u_sel8 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .sel_in(sel_in), .ready_out(rdy3), .ready_in(ready_in),
    .data_out(dout3), .valid_out(v3), .ch_ptr(p3));

  // Uniform view of all instances, zero-extended to the widest config
  logic             obs_rdy [4];
  logic [7:0]       obs_v   [4];
  logic [2:0]       obs_p   [4];
  logic [7:0][15:0] obs_d   [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      obs_rdy[i] = 1'b0;
      obs_v[i]   = '0;
      obs_p[i]   = '0;
      obs_d[i]   = '0;
    end
    obs_rdy[0] = rdy0; obs_v[0] = {4'b0, v0}; obs_p[0] = {1'b0, p0};
    obs_rdy[1] = rdy1; obs_v[1] = {4'b0, v1}; obs_p[1] = {1'b0, p1};
    obs_rdy[2] = rdy2; obs_v[2] = {6'b0, v2}; obs_p[2] = {2'b0, p2};
    obs_rdy[3] = rdy3; obs_v[3] = v3;         obs_p[3] = p3;
    for (int k = 0; k < 4; k++) begin
      obs_d[0][k] = {8'b0, dout0[k*8 +: 8]};
      obs_d[1][k] = {8'b0, dout1[k*8 +: 8]};
    end
    for (int k = 0; k < 2; k++) obs_d[2][k] = {15'b0, dout2[k]};
    for (int k = 0; k < 8; k++) obs_d[3][k] = dout3[k*16 +: 16];
  end

  int cfg_nch  [4];
  int cfg_bw   [4];
  int cfg_mode [4];

  // Reference model: one slot per channel plus destination pointer
  int          m_ptr [4];
  bit          m_occ [4][8];
  logic [15:0] m_dat [4][8];
  int          n_acc [4];
  int          n_del [4];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
  endtask

  task automatic check_state(input int i);
    for (int k = 0; k < cfg_nch[i]; k++) begin
      chk($sformatf("i%0d valid[%0d]", i, k), 32'(obs_v[i][k]), 32'(m_occ[i][k]));
      chk($sformatf("i%0d data[%0d]", i, k), 32'(obs_d[i][k]), 32'(m_dat[i][k]));
    end
    chk($sformatf("i%0d ptr", i), 32'(obs_p[i]), 32'(m_ptr[i]));
  endtask

  // Called between edges with the cycle's inputs applied
  task automatic model_step(input int i);
    int   nch;
    int   d;
    bit   er;
    logic [15:0] mask;
    nch  = cfg_nch[i];
    mask = 16'((1 << cfg_bw[i]) - 1);
    d    = (cfg_mode[i] == 1) ? (int'(sel_in) % nch) : m_ptr[i];
    er   = !m_occ[i][d] || ready_in[d];
    chk($sformatf("i%0d ready_out", i), 32'(obs_rdy[i]), 32'(er));
    for (int k = 0; k < nch; k++)
      if (obs_v[i][k] && ready_in[k]) n_del[i]++;
    if (valid_in && obs_rdy[i]) n_acc[i]++;
    for (int k = 0; k < nch; k++)
      if (m_occ[i][k] && ready_in[k]) m_occ[i][k] = 1'b0;
    if (valid_in && er) begin
      m_occ[i][d] = 1'b1;
      m_dat[i][d] = data_in & mask;
      m_ptr[i]    = (cfg_mode[i] == 1) ? d : (m_ptr[i] + 1) % nch;
    end
  endtask

  initial begin
    cfg_nch  = '{4, 4, 2, 8};
    cfg_bw   = '{8, 8, 1, 16};
    cfg_mode = '{0, 1, 0, 1};
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    sel_in   = '0;
    ready_in = '0;
    #2;
    chk("reset valid", 32'(v0), 32'(0));
    chk("reset data", dout0, 32'(0));
    chk("reset ptr", 32'(p0), 32'(0));
    tick();
    reset_L = 1'b1;

    // Round-robin streaming with all sinks ready
    do_reset();
    ready_in = 8'hFF;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'((i + 1) * 17);
      #1;
      chk("rr ptr seq", 32'(p0), 32'(i % 4));
      chk("rr ready", 32'(rdy0), 32'(1));
      tick();
      chk("rr valid", 32'(v0), 32'(1 << (i % 4)));
      chk("rr data", 32'(dout0[(i % 4) * 8 +: 8]), 32'((i + 1) * 17));
    end
    chk("rr ptr end", 32'(p0), 32'(1));
    valid_in = 1'b0;
    tick();
    chk("rr drained", 32'(v0), 32'(0));
    chk("rr data held", 32'(dout0[7:0]), 32'(8'h55));

    // Round-robin stall: ch1 never drains, pointer comes back around to it
    do_reset();
    ready_in = 8'b1101;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'(8'hA0 + i);
      tick();
    end
    chk("stall valid", 32'(v0), 32'(4'b0011));
    chk("stall ptr", 32'(p0), 32'(1));
    chk("stall ch1", 32'(dout0[15:8]), 32'(8'hA1));
    data_in = 16'h00A5;
    #1;
    chk("stall ready", 32'(rdy0), 32'(0));
    tick();
    chk("stall ptr hold", 32'(p0), 32'(1));
    chk("stall valid2", 32'(v0), 32'(4'b0010));
    chk("stall ch1 kept", 32'(dout0[15:8]), 32'(8'hA1));
    ready_in = 8'hFF;
    #1;
    chk("unstall ready", 32'(rdy0), 32'(1));
    tick();
    chk("unstall valid", 32'(v0), 32'(4'b0010));
    chk("unstall ch1", 32'(dout0[15:8]), 32'(8'hA5));
    chk("unstall ptr", 32'(p0), 32'(2));
    valid_in = 1'b0;

    // Explicit select: back-to-back beats into one channel
    do_reset();
    ready_in = 8'hFF;
    sel_in   = 3'd2;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'(i + 1);
      #1;
      chk("sel ready", 32'(rdy1), 32'(1));
      tick();
      chk("sel valid", 32'(v1), 32'(4'b0100));
      chk("sel data", 32'(dout1[23:16]), 32'(i + 1));
      chk("sel ptr", 32'(p1), 32'(2));
    end
    valid_in = 1'b0;
    tick();
    chk("sel drained", 32'(v1), 32'(0));

    // Explicit select: a full stalled channel does not block another channel
    do_reset();
    ready_in = 8'b0111;
    sel_in   = 3'd3;
    data_in  = 16'h003C;
    valid_in = 1'b1;
    tick();
    chk("sel3 full", 32'(v1), 32'(4'b1000));
    sel_in  = 3'd0;
    data_in = 16'h005A;
    #1;
    chk("sel0 ready", 32'(rdy1), 32'(1));
    tick();
    chk("sel0 valid", 32'(v1), 32'(4'b1001));
    chk("sel3 kept", 32'(dout1[31:24]), 32'(8'h3C));
    chk("sel0 data", 32'(dout1[7:0]), 32'(8'h5A));
    chk("sel0 ptr", 32'(p1), 32'(0));
    valid_in = 1'b0;
    tick();
    chk("sel0 drain", 32'(v1), 32'(4'b1000));

    // Asynchronous reset mid-cycle with ch1/ch3 holding beats
    do_reset();
    ready_in = 8'b0101;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'(8'hB0 + i);
      tick();
    end
    valid_in = 1'b0;
    tick();
    chk("pre-rst valid", 32'(v0), 32'(4'b1010));
    chk("pre-rst ptr", 32'(p0), 32'(0));
    #2;
    reset_L = 1'b0;
    #1;
    chk("async rst valid", 32'(v0), 32'(0));
    chk("async rst data", dout0, 32'(0));
    chk("async rst ptr", 32'(p0), 32'(0));
    chk("rst ready", 32'(rdy0), 32'(1));
    valid_in = 1'b1;
    data_in  = 16'h00FF;
    tick();
    chk("no accept in rst", 32'(v0), 32'(0));
    chk("no ptr in rst", 32'(p0), 32'(0));
    valid_in = 1'b0;
    ready_in = 8'h00;
    reset_L  = 1'b1;
    tick();
    tick();
    chk("no stale valid", 32'(v0), 32'(0));

    // Randomized traffic on all four configurations
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_ptr[i] = 0;
      n_acc[i] = 0;
      n_del[i] = 0;
      for (int k = 0; k < 8; k++) begin
        m_occ[i][k] = 1'b0;
        m_dat[i][k] = '0;
      end
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 4; i++) check_state(i);
      if (cyc < 1480) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 16'($urandom);
        sel_in   = 3'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) ready_in[k] = ($urandom_range(0, 4) < 3);
      end else begin
        valid_in = 1'b0;
        ready_in = 8'hFF;
      end
      #1;
      for (int i = 0; i < 4; i++) model_step(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check_state(i);
      chk($sformatf("i%0d beats once", i), 32'(n_del[i]), 32'(n_acc[i]));
      chk($sformatf("i%0d traffic", i), 32'(n_acc[i] > 100), 32'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
